// File: rtl/lcd_hd44780_responder.sv
// lcd_hd44780_responder
//   Cycle-accurate HD44780-style LCD responder. It sits on the receiving end of
//   the rs/rw/enable/data bus that the LCD writer FSMs drive. It decodes
//   instructions on enable falling edges, holds DDRAM (80 x 8) and CGRAM
//   (64 x 5), the address counter and the display/entry flags, and models the
//   busy flag.
//
// Ports
//   clk, reset        system clock; asynchronous active-high reset
//   rs, rw, enable    LCD bus control (enable is sampled on clk)
//   data_in           bus write data
//   data_out/data_oe  registered read data; bus drive enable (enable & rw)
//   busy              modelled busy flag (BF)
//   addr_counter      address counter (AC)
//   display_on, cursor_on, blink_on, two_line, inc_mode, shift_mode,
//   display_offset    control state that the display-side logic uses
//   mode_err          sticky: function set requested 4-bit mode
//   ovr_err           sticky: a write arrived while busy
//   peek_addr/peek_data        DDRAM inspection port, 1-cycle latency
//   peek_cg_addr/peek_cg_data  CGRAM inspection port, 1-cycle latency
module lcd_hd44780_responder #(
    parameter int unsigned BUSY_CYCLES  = 1850,
    parameter int unsigned CLEAR_CYCLES = 76500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rs,
    input  logic       rw,
    input  logic       enable,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic [6:0] addr_counter,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       inc_mode,
    output logic       shift_mode,
    output logic [5:0] display_offset,
    output logic       mode_err,
    output logic       ovr_err,
    input  logic [6:0] peek_addr,
    output logic [7:0] peek_data,
    input  logic [5:0] peek_cg_addr,
    output logic [7:0] peek_cg_data
);

    localparam int unsigned CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLEARING, ST_BUSY} state_t;

    state_t           state_q, state_d;
    logic             en_q, en_d;
    logic             cmd_rs_q, cmd_rs_d;
    logic [7:0]       cmd_data_q, cmd_data_d;
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic [6:0]       clr_idx_q, clr_idx_d;
    logic [6:0]       ac_q, ac_d;
    logic             tgt_cg_q, tgt_cg_d;
    logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic             two_line_q, two_line_d, inc_q, inc_d, shift_q, shift_d;
    logic [5:0]       offset_q, offset_d;
    logic             mode_err_q, mode_err_d, ovr_err_q, ovr_err_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             rd_step_q, rd_step_d;
    logic [7:0]       peek_data_q, peek_data_d, peek_cg_data_q, peek_cg_data_d;

    logic [7:0] ddram [80];
    logic [4:0] cgram [64];

    logic       dd_we, cg_we;
    logic [6:0] dd_waddr;
    logic [7:0] dd_wdata;
    logic [5:0] cg_waddr;
    logic [4:0] cg_wdata;

    logic       fall, rise;
    logic [7:0] ac_lin;

    // {valid, index}: AC to linear DDRAM index for the current line mode.
    function automatic logic [7:0] ddram_lin(input logic [6:0] ac, input logic two);
        logic [7:0] r;
        r = 8'h00;
        if (two) begin
            if (ac <= 7'h27)                     r = {1'b1, ac};
            else if (ac >= 7'h40 && ac <= 7'h67) r = {1'b1, ac - 7'd24};
        end else if (ac <= 7'h4F) begin
            r = {1'b1, ac};
        end
        return r;
    endfunction

    function automatic logic [6:0] ac_next(input logic [6:0] ac, input logic inc,
                                           input logic cg, input logic two);
        logic [6:0] r;
        if (cg)
            r = {1'b0, inc ? ac[5:0] + 6'd1 : ac[5:0] - 6'd1};
        else if (two) begin
            if (inc) r = (ac == 7'h27) ? 7'h40 : (ac == 7'h67) ? 7'h00 : ac + 7'd1;
            else     r = (ac == 7'h40) ? 7'h27 : (ac == 7'h00) ? 7'h67 : ac - 7'd1;
        end else begin
            if (inc) r = (ac == 7'h4F) ? 7'h00 : ac + 7'd1;
            else     r = (ac == 7'h00) ? 7'h4F : ac - 7'd1;
        end
        return r;
    endfunction

    function automatic logic [5:0] off_step(input logic [5:0] o, input logic up);
        if (up) return (o == 6'd39) ? 6'd0 : o + 6'd1;
        else    return (o == 6'd0) ? 6'd39 : o - 6'd1;
    endfunction

    assign busy   = (state_q != ST_IDLE);
    assign fall   = en_q & ~enable;
    assign rise   = ~en_q & enable;
    assign ac_lin = ddram_lin(ac_q, two_line_q);

    always_comb begin
        state_d        = state_q;
        en_d           = enable;
        cmd_rs_d       = cmd_rs_q;
        cmd_data_d     = cmd_data_q;
        busy_cnt_d     = busy_cnt_q;
        clr_idx_d      = clr_idx_q;
        ac_d           = ac_q;
        tgt_cg_d       = tgt_cg_q;
        disp_d         = disp_q;
        cur_d          = cur_q;
        blink_d        = blink_q;
        two_line_d     = two_line_q;
        inc_d          = inc_q;
        shift_d        = shift_q;
        offset_d       = offset_q;
        mode_err_d     = mode_err_q;
        ovr_err_d      = ovr_err_q;
        data_out_d     = data_out_q;
        rd_step_d      = rd_step_q;
        dd_we          = 1'b0;
        dd_waddr       = '0;
        dd_wdata       = '0;
        cg_we          = 1'b0;
        cg_waddr       = '0;
        cg_wdata       = '0;
        peek_data_d    = (peek_addr < 7'd80) ? ddram[peek_addr] : 8'h00;
        peek_cg_data_d = {3'b000, cgram[peek_cg_addr]};

        // Reads: data captured on the rising edge, presented next cycle.
        if (rise && rw) begin
            if (rs && !busy) begin
                rd_step_d = 1'b1;
                if (tgt_cg_q)       data_out_d = {3'b000, cgram[ac_q[5:0]]};
                else if (ac_lin[7]) data_out_d = ddram[ac_lin[6:0]];
                else                data_out_d = 8'h00;
            end else begin
                data_out_d = {busy, ac_q};
            end
        end

        if (fall) begin
            rd_step_d = 1'b0;
            if (!rw && busy) ovr_err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    if (!rw) begin
                        cmd_rs_d   = rs;
                        cmd_data_d = data_in;
                        state_d    = ST_EXEC;
                    end else if (rd_step_q) begin
                        // A data read advances AC only once the strobe ends.
                        ac_d = ac_next(ac_q, inc_q, tgt_cg_q, two_line_q);
                    end
                end
            end
            ST_EXEC: begin
                busy_cnt_d = BUSY_LOAD;
                state_d    = ST_BUSY;
                if (cmd_rs_q) begin
                    if (tgt_cg_q) begin
                        cg_we    = 1'b1;
                        cg_waddr = ac_q[5:0];
                        cg_wdata = cmd_data_q[4:0];
                    end else if (ac_lin[7]) begin
                        dd_we    = 1'b1;
                        dd_waddr = ac_lin[6:0];
                        dd_wdata = cmd_data_q;
                    end
                    ac_d = ac_next(ac_q, inc_q, tgt_cg_q, two_line_q);
                    if (shift_q) offset_d = off_step(offset_q, inc_q);
                end else begin
                    casez (cmd_data_q)
                        8'b1???????: begin
                            ac_d     = cmd_data_q[6:0];
                            tgt_cg_d = 1'b0;
                        end
                        8'b01??????: begin
                            ac_d     = {1'b0, cmd_data_q[5:0]};
                            tgt_cg_d = 1'b1;
                        end
                        8'b001?????: begin
                            two_line_d = cmd_data_q[3];
                            if (!cmd_data_q[4]) mode_err_d = 1'b1;
                        end
                        8'b0001????: begin
                            if (cmd_data_q[3]) offset_d = off_step(offset_q, cmd_data_q[2]);
                            else               ac_d = ac_next(ac_q, cmd_data_q[2], tgt_cg_q, two_line_q);
                        end
                        8'b00001???: begin
                            disp_d  = cmd_data_q[2];
                            cur_d   = cmd_data_q[1];
                            blink_d = cmd_data_q[0];
                        end
                        8'b000001??: begin
                            inc_d   = cmd_data_q[1];
                            shift_d = cmd_data_q[0];
                        end
                        8'b0000001?: begin
                            ac_d       = '0;
                            offset_d   = '0;
                            busy_cnt_d = CLEAR_LOAD;
                        end
                        8'b00000001: begin
                            busy_cnt_d = CLEAR_LOAD;
                            clr_idx_d  = '0;
                            state_d    = ST_CLEARING;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CLEARING: begin
                dd_we    = 1'b1;
                dd_waddr = clr_idx_q;
                dd_wdata = 8'h20;
                if (busy_cnt_q != '0) busy_cnt_d = busy_cnt_q - CNT_W'(1);
                if (clr_idx_q == 7'd79) begin
                    ac_d     = '0;
                    tgt_cg_d = 1'b0;
                    inc_d    = 1'b1;
                    offset_d = '0;
                    state_d  = ST_BUSY;
                end else begin
                    clr_idx_d = clr_idx_q + 7'd1;
                end
            end
            ST_BUSY: begin
                if (busy_cnt_q == '0) state_d = ST_IDLE;
                else                  busy_cnt_d = busy_cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            en_q           <= 1'b0;
            cmd_rs_q       <= 1'b0;
            cmd_data_q     <= '0;
            busy_cnt_q     <= '0;
            clr_idx_q      <= '0;
            ac_q           <= '0;
            tgt_cg_q       <= 1'b0;
            disp_q         <= 1'b0;
            cur_q          <= 1'b0;
            blink_q        <= 1'b0;
            two_line_q     <= 1'b0;
            inc_q          <= 1'b1;
            shift_q        <= 1'b0;
            offset_q       <= '0;
            mode_err_q     <= 1'b0;
            ovr_err_q      <= 1'b0;
            data_out_q     <= '0;
            rd_step_q      <= 1'b0;
            peek_data_q    <= '0;
            peek_cg_data_q <= '0;
        end else begin
            state_q        <= state_d;
            en_q           <= en_d;
            cmd_rs_q       <= cmd_rs_d;
            cmd_data_q     <= cmd_data_d;
            busy_cnt_q     <= busy_cnt_d;
            clr_idx_q      <= clr_idx_d;
            ac_q           <= ac_d;
            tgt_cg_q       <= tgt_cg_d;
            disp_q         <= disp_d;
            cur_q          <= cur_d;
            blink_q        <= blink_d;
            two_line_q     <= two_line_d;
            inc_q          <= inc_d;
            shift_q        <= shift_d;
            offset_q       <= offset_d;
            mode_err_q     <= mode_err_d;
            ovr_err_q      <= ovr_err_d;
            data_out_q     <= data_out_d;
            rd_step_q      <= rd_step_d;
            peek_data_q    <= peek_data_d;
            peek_cg_data_q <= peek_cg_data_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (dd_we) ddram[dd_waddr] <= dd_wdata;
        if (cg_we) cgram[cg_waddr] <= cg_wdata;
    end

    assign data_out       = data_out_q;
    assign data_oe        = enable & rw;
    assign addr_counter   = ac_q;
    assign display_on     = disp_q;
    assign cursor_on      = cur_q;
    assign blink_on       = blink_q;
    assign two_line       = two_line_q;
    assign inc_mode       = inc_q;
    assign shift_mode     = shift_q;
    assign display_offset = offset_q;
    assign mode_err       = mode_err_q;
    assign ovr_err        = ovr_err_q;
    assign peek_data      = peek_data_q;
    assign peek_cg_data   = peek_cg_data_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb_lcd_hd44780_responder
//   Directed bench for lcd_hd44780_responder with short busy timings. Expected
//   read and peek values are pushed to a scoreboard queue when the access is
//   issued and popped when the DUT output is sampled; DDRAM expectations come
//   from a model array maintained alongside the writes.
module tb_lcd_hd44780_responder;

    localparam int unsigned BUSY_C  = 20;
    localparam int unsigned CLEAR_C = 100;

    logic       clk = 1'b0;
    logic       reset, rs, rw, enable;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe, busy;
    logic [6:0] addr_counter;
    logic       display_on, cursor_on, blink_on, two_line, inc_mode, shift_mode;
    logic [5:0] display_offset;
    logic       mode_err, ovr_err;
    logic [6:0] peek_addr;
    logic [7:0] peek_data;
    logic [5:0] peek_cg_addr;
    logic [7:0] peek_cg_data;

    lcd_hd44780_responder #(
        .BUSY_CYCLES (BUSY_C),
        .CLEAR_CYCLES(CLEAR_C)
    ) dut (
        .clk(clk), .reset(reset), .rs(rs), .rw(rw), .enable(enable),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .busy(busy),
        .addr_counter(addr_counter), .display_on(display_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .two_line(two_line), .inc_mode(inc_mode),
        .shift_mode(shift_mode), .display_offset(display_offset),
        .mode_err(mode_err), .ovr_err(ovr_err), .peek_addr(peek_addr),
        .peek_data(peek_data), .peek_cg_addr(peek_cg_addr), .peek_cg_data(peek_cg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_item_t;

    sb_item_t   sb_q[$];
    logic [7:0] model_dd [80];
    logic [7:0] cg_bytes [8];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic sb_push(input string tag, input logic [7:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_pop_check(input logic [7:0] obs);
        sb_item_t it;
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            it = sb_q.pop_front();
            check(it.tag, 32'(obs), 32'(it.exp));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 3 * CLEAR_C) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic bus_write(input logic rs_v, input logic [7:0] d);
        rs      = rs_v;
        rw      = 1'b0;
        data_in = d;
        enable  = 1'b1;
        tick();
        enable = 1'b0;
        tick();
    endtask

    task automatic cmd(input logic rs_v, input logic [7:0] d);
        wait_idle();
        bus_write(rs_v, d);
    endtask

    task automatic bus_read(input logic rs_v, input logic [7:0] exp, input string tag);
        sb_push(tag, exp);
        rs     = rs_v;
        rw     = 1'b1;
        enable = 1'b1;
        tick();
        check({tag, "_oe"}, 32'(data_oe), 32'd1);
        sb_pop_check(data_out);
        enable = 1'b0;
        tick();
        rw = 1'b0;
    endtask

    task automatic peek_dd(input int unsigned idx);
        sb_push($sformatf("ddram[%0d]", idx), model_dd[idx]);
        peek_addr = 7'(idx);
        tick();
        sb_pop_check(peek_data);
    endtask

    task automatic peek_cg(input int unsigned idx, input logic [7:0] exp);
        sb_push($sformatf("cgram[%0d]", idx), exp);
        peek_cg_addr = 6'(idx);
        tick();
        sb_pop_check(peek_cg_data);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        cg_bytes = '{8'h1F, 8'h11, 8'h31, 8'hF1, 8'h1F, 8'h0A, 8'h15, 8'hE4};
        reset = 1'b1; rs = 1'b0; rw = 1'b0; enable = 1'b0; data_in = '0;
        peek_addr = '0; peek_cg_addr = '0;
        repeat (3) tick();

        check("rst_ac",       32'(addr_counter), 32'h00);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_inc",      32'(inc_mode), 32'd1);
        check("rst_two_line", 32'(two_line), 32'd0);
        check("rst_disp",     32'({display_on, cursor_on, blink_on, shift_mode}), 32'h0);
        check("rst_dout",     32'(data_out), 32'h00);
        check("rst_errs",     32'({mode_err, ovr_err}), 32'h0);
        check("rst_offset",   32'(display_offset), 32'h00);
        reset = 1'b0;
        tick();

        // Function set, display control, then clear with exact busy length.
        cmd(1'b0, 8'h38);
        cmd(1'b0, 8'h0C);
        wait_idle();
        check("fs_two_line", 32'(two_line), 32'd1);
        check("dc_flags",    32'({display_on, cursor_on, blink_on}), 32'b100);
        check("fs_mode_err", 32'(mode_err), 32'd0);
        cmd(1'b0, 8'h01);
        n = 0;
        while (busy === 1'b1 && n < 3 * CLEAR_C) begin
            n++;
            tick();
        end
        check("clear_busy_len", 32'(n), 32'(CLEAR_C + 1));
        for (int i = 0; i < 80; i++) model_dd[i] = 8'h20;
        for (int i = 0; i < 80; i++) peek_dd(i);
        check("clear_ac", 32'(addr_counter), 32'h00);

        // CGRAM fill: only the low five bits are stored.
        cmd(1'b0, 8'h40);
        for (int i = 0; i < 8; i++) cmd(1'b1, cg_bytes[i]);
        wait_idle();
        for (int i = 0; i < 8; i++) peek_cg(i, {3'b000, cg_bytes[i][4:0]});
        check("cg_ac", 32'(addr_counter), 32'h08);

        // Two-line wrap 0x27 -> 0x40 and 0x67 -> 0x00.
        cmd(1'b0, 8'hA7);
        cmd(1'b1, 8'h41); model_dd[39] = 8'h41;
        cmd(1'b1, 8'h42); model_dd[40] = 8'h42;
        wait_idle();
        peek_dd(39);
        peek_dd(40);
        check("wrap_ac_41", 32'(addr_counter), 32'h41);
        cmd(1'b0, 8'hE7);
        cmd(1'b1, 8'h43); model_dd[79] = 8'h43;
        wait_idle();
        peek_dd(79);
        check("wrap_ac_00", 32'(addr_counter), 32'h00);

        // Decrement wrap 0x00 -> 0x67.
        cmd(1'b0, 8'h04);
        cmd(1'b1, 8'h46); model_dd[0] = 8'h46;
        wait_idle();
        check("dec_wrap_ac", 32'(addr_counter), 32'h67);
        peek_dd(0);
        cmd(1'b0, 8'h06);

        // Write while busy is dropped and flagged.
        cmd(1'b0, 8'h80);
        bus_write(1'b1, 8'h41);
        check("ovr_err", 32'(ovr_err), 32'd1);
        wait_idle();
        check("ovr_ac", 32'(addr_counter), 32'h00);
        peek_dd(0);

        // Status reads during and after busy; data read steps AC.
        cmd(1'b0, 8'h85);
        tick();
        bus_read(1'b0, 8'h85, "rd_status_busy");
        wait_idle();
        bus_read(1'b0, 8'h05, "rd_status_idle");
        cmd(1'b0, 8'hA7);
        wait_idle();
        bus_read(1'b1, model_dd[39], "rd_data");
        check("rd_step_ac", 32'(addr_counter), 32'h40);

        // Entry mode with display shift.
        cmd(1'b0, 8'h07);
        cmd(1'b1, 8'h55); model_dd[40] = 8'h55;
        wait_idle();
        check("shift_offset", 32'(display_offset), 32'd1);
        check("shift_ac", 32'(addr_counter), 32'h41);
        peek_dd(40);

        // Reset in the middle of a clear, with index 40 about to be written.
        cmd(1'b0, 8'h01);
        repeat (41) tick();
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ac",   32'(addr_counter), 32'h00);
        check("mid_rst_flags",
              32'({inc_mode, two_line, display_on, shift_mode, mode_err, ovr_err}), 32'b100000);
        check("mid_rst_offset", 32'(display_offset), 32'h00);
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 40; i++) model_dd[i] = 8'h20;
        for (int i = 0; i < 80; i++) peek_dd(i);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_responder.md
Name: lcd_hd44780_responder

Overview:
- Cycle-accurate HD44780-style LCD responder: the receiving end of the rs/rw/enable/data[7:0] bus that the team's LCD writer FSMs drive.
- Decodes instructions on enable falling edges and maintains DDRAM (80 B), CGRAM (64 × 5 b), address counter, entry and display flags, and a modelled busy flag.
- Used as a bench-side and on-FPGA display model. The team's VGA and debug paths read its contents through peek ports.

Parameters:
- BUSY_CYCLES, 1850: clk cycles busy after any non-clear, non-home instruction or data write (37 µs at 50 MHz).
- CLEAR_CYCLES, 76500: clk cycles busy after clear display or return home. Must be ≥ 80.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rs  input  1  0 = instruction/status, 1 = data.
- rw  input  1  0 = write, 1 = read.
- enable  input  1  LCD E strobe, synchronous to clk. Write operations are latched on its falling edge.
- data_in  input  8  bus data from the writer.
- data_out  output  8  read data.
- data_oe  output  1  high while enable=1 and rw=1.
- busy  output  1  modelled busy flag (BF).
- addr_counter  output  7  AC.
- display_on, cursor_on, blink_on  output  1 each  display control bits D, C, B.
- two_line  output  1  function-set N bit.
- inc_mode, shift_mode  output  1 each  entry-mode I/D and S bits.
- display_offset  output  6  display shift, 0..39.
- mode_err  output  1  sticky: function set with DL=0 (4-bit mode) was received.
- ovr_err  output  1  sticky: a write arrived while busy=1.
- peek_addr  input  7  linear DDRAM index, 0..79.
- peek_data  output  8  DDRAM[peek_addr], 1-cycle latency.
- peek_cg_addr  input  6  CGRAM index.
- peek_cg_data  output  8  {3'b0, CGRAM[peek_cg_addr]}, 1-cycle latency.

Behaviour:
- Reset (asynchronous, applies at any time, including mid-clear):
  - All outputs 0, except inc_mode=1 and two_line=0.
  - AC=0, target=DDRAM, FSM=IDLE, counters=0.
  - RAM contents are not cleared.
- Edge detection:
  - en_d registers enable.
  - Falling edge = en_d & ~enable. rs, rw, data_in are sampled in that same cycle.
  - Rising edge = ~en_d & enable.
- Write on falling edge with rw=0 and busy=0 → EXEC. Write with busy=1 → dropped, ovr_err set.
- Instruction decode (rs=0, priority by highest set bit):
  - 1xxxxxxx (set DDRAM address): AC=data[6:0], target=DDRAM.
  - 01xxxxxx (set CGRAM address): AC={1'b0, data[5:0]}, target=CGRAM.
  - 001DNFxx (function set): two_line=N. If D=0, mode_err is set.
  - 0001SRxx (cursor/display shift): S=1 shifts display_offset (R=1 → +1, else −1, mod 40). S=0 moves AC (R=1 → +1, else −1) using the wrap rules below.
  - 00001DCB (display control): sets display_on, cursor_on, blink_on.
  - 000001IS (entry mode): sets inc_mode, shift_mode.
  - 0000001x (return home): AC=0, display_offset=0.
  - 00000001 (clear display): enter CLEARING.
- Data write (rs=1):
  - Store data_in to DDRAM[lin(AC)], or data_in[4:0] to CGRAM[AC[5:0]], depending on target.
  - Then step AC per inc_mode.
  - If shift_mode=1, also shift display_offset in the same direction.
- DDRAM linear map:
  - two_line=1: 0x00–0x27 → 0–39; 0x40–0x67 → 40–79.
  - two_line=0: 0x00–0x4F → 0–79.
  - Out-of-range AC: writes are ignored, AC still steps.
- AC step and wrap:
  - two_line=1, increment: 0x27→0x40, 0x67→0x00.
  - two_line=1, decrement: 0x40→0x27, 0x00→0x67.
  - two_line=0: 0x4F↔0x00.
  - CGRAM: 6-bit wrap, 0x3F↔0x00.
- FSM states: IDLE, EXEC, CLEARING, BUSY.
  - IDLE → EXEC on an accepted write.
  - EXEC (1 cycle): applies the effect, loads busy_cnt (CLEAR_CYCLES−1 for clear/home, else BUSY_CYCLES−1), then goes to CLEARING for clear or BUSY otherwise.
  - CLEARING: writes 0x20 to one DDRAM location per cycle, index 0..79, while busy_cnt decrements. After index 79: AC=0, target=DDRAM, inc_mode=1, display_offset=0, then → BUSY.
  - BUSY: decrement busy_cnt. At 0 → IDLE.
  - busy=1 in EXEC, CLEARING and BUSY.
- Reads, rising edge with rw=1, data_out registered next cycle:
  - rs=0: data_out={busy, AC}. Allowed while busy.
  - rs=1, busy=0: data_out = RAM at AC. AC steps on the following falling edge.
  - rs=1, busy=1: data_out={busy, AC}, and no AC step occurs.
- Simultaneous events: a peek read in the same cycle as a RAM write returns the old data.

Test Plan:
- Reset, then write 0x38, 0x0C, 0x01, each after busy falls:
  - two_line=1, display_on=1, cursor_on=0.
  - busy high exactly CLEAR_CYCLES+1 cycles after the 0x01 fall.
  - peek_data=0x20 for indices 0..79; AC=0.
- Write 0x40, then 8 data bytes 0x1F,0x11,…:
  - peek_cg_data(0..7) matches bytes[4:0].
  - AC=0x08, target=CGRAM.
- two_line=1, write 0xA7 (AC=0x27), then data 0x41, 0x42:
  - DDRAM[39]=0x41, DDRAM[40]=0x42, AC=0x41.
  - Repeat with AC=0x67: wraps to 0x00.
- Write 0x80, then immediately 0x41 while busy=1:
  - Second write dropped, ovr_err=1.
  - DDRAM[0] unchanged; AC=0x00.
- Reset asserted at clear index 40:
  - Outputs return to reset values immediately.
  - DDRAM[0..39]=0x20, DDRAM[40..79] unchanged.
- Read with rs=0, rw=1 during BUSY after 0x85:
  - data_out=0x85 (BF=1, AC=0x05).
  - After busy falls: 0x05.
  - Entry mode 0x07 plus one data write: display_offset=1.
